// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES state geometry helpers (row offsets, byte indexing, NB legality)
//
// Purpose: helpers shared by the ShiftRows pipe and the future MixColumns pipe.
//   shift_of(nb, r)    : Rijndael ShiftRows offset C(r) for a state of nb columns
//   byte_idx(nb, r, c) : linear byte index of (row r, column c), column-major
//   nb_legal(nb)       : 1 when nb is a supported block width (4, 6 or 8)
package aes_pkg;

    localparam int AES_ROWS = 4;

    function automatic bit nb_legal(input int nb);
        return (nb == 4) || (nb == 6) || (nb == 8);
    endfunction

    // Rows 2 and 3 shift further for the 256-bit block so that every row
    // still lands on a distinct column set.
    function automatic int shift_of(input int nb, input int r);
        int s;
        case (r)
            0:       s = 0;
            1:       s = 1;
            2:       s = (nb == 8) ? 3 : 2;
            default: s = (nb == 8) ? 4 : 3;
        endcase
        return s;
    endfunction

    // Byte k = row k%4, column k/4, so (r, c) sits at 4*c + r.
    function automatic int byte_idx(input int nb, input int r, input int c);
        return (c % nb) * AES_ROWS + r;
    endfunction

endpackage

// File: rtl/aes_pipe_stage.sv
// rtl/aes_pipe_stage.sv - single valid/ready register slice with synchronous flush
//
// Purpose: one elastic pipeline register; loads whenever empty or when the
//          downstream slice is taking the current entry.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   flush              synchronous clear of the held entry (payload kept)
//   in_valid/in_ready  upstream handshake (in_ready is the load condition)
//   in_payload         PW-bit payload from upstream
//   out_valid/out_ready downstream handshake
//   out_payload        PW-bit held payload
module aes_pipe_stage #(
    parameter int PW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_payload,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_payload
);

    logic          r_valid;
    logic [PW-1:0] r_payload;
    logic          w_load;

    // An empty slice always accepts, so bubbles collapse under a stall.
    assign w_load   = !r_valid || out_ready;
    assign in_ready = w_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_payload <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_payload <= in_payload;
            end
        end
    end

    assign out_valid   = r_valid;
    assign out_payload = r_payload;

endmodule

// File: rtl/aes_shift_rows_pipe.sv
// rtl/aes_shift_rows_pipe.sv - pipelined AES ShiftRows/InvShiftRows for NB = 4, 6, 8
//
// Purpose: permutes the state combinationally, then carries it with its mode
//          and tag through STAGES elastic register slices.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   flush                    synchronous drop of all in-flight blocks
//   in_valid/in_ready        input handshake
//   in_data[32*NB]           state, byte 0 at the MSB, column-major
//   in_inv                   0 = ShiftRows, 1 = InvShiftRows
//   in_tag[TAG_W]            opaque sideband
//   out_valid/out_ready      output handshake
//   out_data/out_inv/out_tag permuted state, echoed mode and tag
module aes_shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int NB     = 4,
    parameter int STAGES = 1,
    parameter int TAG_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [32*NB-1:0]   in_data,
    input  logic               in_inv,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [32*NB-1:0]   out_data,
    output logic               out_inv,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int DW = 32 * NB;
    localparam int PW = DW + 1 + TAG_W;

    if (!nb_legal(NB)) begin : g_bad_nb
        $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("aes_shift_rows_pipe: STAGES must be 1..4");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("aes_shift_rows_pipe: TAG_W must be at least 1");
    end

    logic [DW-1:0] w_perm;

    // Inverse source column uses c + NB - C(r) so no intermediate goes negative.
    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < AES_ROWS; r++) begin : g_row
            localparam int SH    = shift_of(NB, r);
            localparam int FWD_C = (c + SH) % NB;
            localparam int INV_C = (c + NB - SH) % NB;
            localparam int DST   = byte_idx(NB, r, c);
            localparam int FSRC  = byte_idx(NB, r, FWD_C);
            localparam int ISRC  = byte_idx(NB, r, INV_C);
            assign w_perm[DW-1-8*DST -: 8] = in_inv ? in_data[DW-1-8*ISRC -: 8]
                                                    : in_data[DW-1-8*FSRC -: 8];
        end
    end

    // Index k is the handshake into slice k; index STAGES is the output port.
    logic          w_valid   [0:STAGES];
    logic          w_ready   [0:STAGES];
    logic [PW-1:0] w_payload [0:STAGES];

    assign w_valid[0]       = in_valid && !flush;
    assign w_payload[0]     = {w_perm, in_inv, in_tag};
    assign w_ready[STAGES]  = out_ready;
    assign in_ready         = w_ready[0] && !flush;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        aes_pipe_stage #(
            .PW (PW)
        ) u_stage (
            .clk         (clk),
            .rst_n       (rst_n),
            .flush       (flush),
            .in_valid    (w_valid[k]),
            .in_ready    (w_ready[k]),
            .in_payload  (w_payload[k]),
            .out_valid   (w_valid[k+1]),
            .out_ready   (w_ready[k+1]),
            .out_payload (w_payload[k+1])
        );
    end

    assign out_valid = w_valid[STAGES];
    assign out_data  = w_payload[STAGES][PW-1 -: DW];
    assign out_inv   = w_payload[STAGES][TAG_W];
    assign out_tag   = w_payload[STAGES][TAG_W-1:0];

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// tb/tb_aes_shift_rows_pipe.sv - directed self-checking bench for aes_shift_rows_pipe
module tb_aes_shift_rows_pipe;

    localparam logic [127:0] FIPS_IN = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] FIPS_SR = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    // a: NB4 S1, b: NB8 S1, c: NB6 S1, d: NB4 S3, e: NB4 S2
    logic         a_flush, a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_ready, a_out_inv;
    logic [127:0] a_in_data, a_out_data;
    logic [3:0]   a_in_tag, a_out_tag;
    logic         b_flush, b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready, b_out_inv;
    logic [255:0] b_in_data, b_out_data;
    logic [3:0]   b_in_tag, b_out_tag;
    logic         c_flush, c_in_valid, c_in_ready, c_in_inv, c_out_valid, c_out_ready, c_out_inv;
    logic [191:0] c_in_data, c_out_data;
    logic [3:0]   c_in_tag, c_out_tag;
    logic         d_flush, d_in_valid, d_in_ready, d_in_inv, d_out_valid, d_out_ready, d_out_inv;
    logic [127:0] d_in_data, d_out_data;
    logic [3:0]   d_in_tag, d_out_tag;
    logic         e_flush, e_in_valid, e_in_ready, e_in_inv, e_out_valid, e_out_ready, e_out_inv;
    logic [127:0] e_in_data, e_out_data;
    logic [3:0]   e_in_tag, e_out_tag;

    aes_shift_rows_pipe #(.NB(4), .STAGES(1), .TAG_W(4)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_inv(a_in_inv), .in_tag(a_in_tag), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .out_inv(a_out_inv), .out_tag(a_out_tag));
    aes_shift_rows_pipe #(.NB(8), .STAGES(1), .TAG_W(4)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_inv(b_in_inv), .in_tag(b_in_tag), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .out_inv(b_out_inv), .out_tag(b_out_tag));
    aes_shift_rows_pipe #(.NB(6), .STAGES(1), .TAG_W(4)) u_c (
        .clk(clk), .rst_n(rst_n), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .in_inv(c_in_inv), .in_tag(c_in_tag), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_data(c_out_data), .out_inv(c_out_inv), .out_tag(c_out_tag));
    aes_shift_rows_pipe #(.NB(4), .STAGES(3), .TAG_W(4)) u_d (
        .clk(clk), .rst_n(rst_n), .flush(d_flush), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .in_data(d_in_data), .in_inv(d_in_inv), .in_tag(d_in_tag), .out_valid(d_out_valid),
        .out_ready(d_out_ready), .out_data(d_out_data), .out_inv(d_out_inv), .out_tag(d_out_tag));
    aes_shift_rows_pipe #(.NB(4), .STAGES(2), .TAG_W(4)) u_e (
        .clk(clk), .rst_n(rst_n), .flush(e_flush), .in_valid(e_in_valid), .in_ready(e_in_ready),
        .in_data(e_in_data), .in_inv(e_in_inv), .in_tag(e_in_tag), .out_valid(e_out_valid),
        .out_ready(e_out_ready), .out_data(e_out_data), .out_inv(e_out_inv), .out_tag(e_out_tag));

    task automatic test_reset();
        @(negedge clk);
        total++; if (a_out_valid !== 1'b0 || a_out_data !== '0 || a_out_inv !== 1'b0 || a_out_tag !== 4'h0) begin
            bad++; $display("FAIL reset_a_out: valid=%b data=%h inv=%b tag=%h want all zero", a_out_valid, a_out_data, a_out_inv, a_out_tag); end
        total++; if (b_out_valid !== 1'b0 || b_out_data !== '0) begin
            bad++; $display("FAIL reset_b_out: valid=%b data=%h want 0", b_out_valid, b_out_data); end
        total++; if (d_out_valid !== 1'b0 || d_out_data !== '0 || d_out_tag !== 4'h0) begin
            bad++; $display("FAIL reset_d_out: valid=%b data=%h tag=%h want 0", d_out_valid, d_out_data, d_out_tag); end
        total++; if ({a_in_ready, b_in_ready, c_in_ready, d_in_ready, e_in_ready} !== 5'b11111) begin
            bad++; $display("FAIL reset_in_ready: got %b want 11111", {a_in_ready, b_in_ready, c_in_ready, d_in_ready, e_in_ready}); end
    endtask

    task automatic test_fips_nb4();
        @(negedge clk);
        a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_data = FIPS_IN; a_in_inv = 1'b0; a_in_tag = 4'h5;
        @(negedge clk);
        total++; if (a_out_valid !== 1'b1 || a_out_data !== FIPS_SR || a_out_inv !== 1'b0 || a_out_tag !== 4'h5) begin
            bad++; $display("FAIL fips_fwd: valid=%b data=%h inv=%b tag=%h want 1 %h 0 5", a_out_valid, a_out_data, a_out_inv, a_out_tag, FIPS_SR); end
        a_in_data = FIPS_SR; a_in_inv = 1'b1; a_in_tag = 4'hA;
        @(negedge clk);
        total++; if (a_out_valid !== 1'b1 || a_out_data !== FIPS_IN || a_out_inv !== 1'b1 || a_out_tag !== 4'hA) begin
            bad++; $display("FAIL fips_inv: valid=%b data=%h inv=%b tag=%h want 1 %h 1 a", a_out_valid, a_out_data, a_out_inv, a_out_tag, FIPS_IN); end
        a_in_valid = 1'b0;
        @(negedge clk);
        total++; if (a_out_valid !== 1'b0) begin
            bad++; $display("FAIL fips_drain: out_valid=%b want 0", a_out_valid); end
    endtask

    task automatic test_nb8();
        logic [255:0] v8;
        logic [255:0] fwd;
        bit           row0_ok;
        for (int k = 0; k < 32; k++) v8[255-8*k -: 8] = 8'(k);
        @(negedge clk);
        b_out_ready = 1'b1; b_in_valid = 1'b1; b_in_data = v8; b_in_inv = 1'b0; b_in_tag = 4'h3;
        @(negedge clk);
        fwd = b_out_data;
        total++; if (b_out_valid !== 1'b1 || b_out_data[255:224] !== 32'h00050e13 || b_out_tag !== 4'h3 || b_out_inv !== 1'b0) begin
            bad++; $display("FAIL nb8_fwd_col0: valid=%b col0=%h tag=%h inv=%b want 1 00050e13 3 0", b_out_valid, b_out_data[255:224], b_out_tag, b_out_inv); end
        row0_ok = 1'b1;
        for (int c = 0; c < 8; c++) if (b_out_data[255-32*c -: 8] !== 8'(4*c)) row0_ok = 1'b0;
        total++; if (!row0_ok) begin
            bad++; $display("FAIL nb8_row0: data=%h row0 bytes not 00,04,..,1c", b_out_data); end
        b_in_data = v8; b_in_inv = 1'b1; b_in_tag = 4'h4;
        @(negedge clk);
        total++; if (b_out_valid !== 1'b1 || b_out_data[255:224] !== 32'h001d1613 || b_out_inv !== 1'b1 || b_out_tag !== 4'h4) begin
            bad++; $display("FAIL nb8_inv_col0: valid=%b col0=%h inv=%b tag=%h want 1 001d1613 1 4", b_out_valid, b_out_data[255:224], b_out_inv, b_out_tag); end
        b_in_data = fwd; b_in_inv = 1'b1;
        @(negedge clk);
        total++; if (b_out_data !== v8) begin
            bad++; $display("FAIL nb8_roundtrip: got %h want %h", b_out_data, v8); end
        b_in_valid = 1'b0;
    endtask

    task automatic test_nb6();
        logic [191:0] v6;
        logic [191:0] fwd;
        for (int k = 0; k < 24; k++) v6[191-8*k -: 8] = 8'(k);
        @(negedge clk);
        c_out_ready = 1'b1; c_in_valid = 1'b1; c_in_data = v6; c_in_inv = 1'b0; c_in_tag = 4'h6;
        @(negedge clk);
        fwd = c_out_data;
        total++; if (c_out_valid !== 1'b1 || c_out_data[191:160] !== 32'h00050a0f || c_out_tag !== 4'h6 || c_out_inv !== 1'b0) begin
            bad++; $display("FAIL nb6_fwd_col0: valid=%b col0=%h tag=%h inv=%b want 1 00050a0f 6 0", c_out_valid, c_out_data[191:160], c_out_tag, c_out_inv); end
        c_in_data = fwd; c_in_inv = 1'b1;
        @(negedge clk);
        total++; if (c_out_data !== v6 || c_out_inv !== 1'b1) begin
            bad++; $display("FAIL nb6_roundtrip: got %h inv=%b want %h 1", c_out_data, c_out_inv, v6); end
        c_in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int           sent = 0;
        int           rcv = 0;
        int           cyc = 0;
        int           first_out = -1;
        bit           saw_full = 1'b0;
        bit           stall_prev = 1'b0;
        logic [127:0] prev_data;
        logic [3:0]   prev_tag;
        logic         prev_inv;
        logic [127:0] exp_data;
        while (rcv < 8 && cyc < 40) begin
            @(negedge clk);
            d_out_ready = !(cyc >= 4 && cyc <= 9);
            if (sent < 8) begin
                d_in_valid = 1'b1;
                d_in_inv   = sent[0];
                d_in_data  = sent[0] ? FIPS_SR : FIPS_IN;
                d_in_tag   = 4'(sent);
            end else begin
                d_in_valid = 1'b0;
            end
            #1;
            if (stall_prev) begin
                total++; if (d_out_valid !== 1'b1 || d_out_data !== prev_data || d_out_tag !== prev_tag || d_out_inv !== prev_inv) begin
                    bad++; $display("FAIL b2b_stall_hold: cyc=%0d valid=%b data=%h tag=%h inv=%b want held %h %h %b", cyc, d_out_valid, d_out_data, d_out_tag, d_out_inv, prev_data, prev_tag, prev_inv); end
            end
            total++; if (d_in_ready !== ((sent - rcv) < 3 || d_out_ready)) begin
                bad++; $display("FAIL b2b_in_ready: cyc=%0d got %b held=%0d out_ready=%b", cyc, d_in_ready, sent - rcv, d_out_ready); end
            if (!d_in_ready) saw_full = 1'b1;
            if (d_out_valid && first_out < 0) first_out = cyc;
            if (d_out_valid && d_out_ready) begin
                exp_data = rcv[0] ? FIPS_IN : FIPS_SR;
                total++; if (d_out_tag !== 4'(rcv) || d_out_inv !== rcv[0] || d_out_data !== exp_data) begin
                    bad++; $display("FAIL b2b_order: idx=%0d tag=%h inv=%b data=%h want %h %b %h", rcv, d_out_tag, d_out_inv, d_out_data, 4'(rcv), rcv[0], exp_data); end
                rcv++;
            end
            if (d_in_valid && d_in_ready) sent++;
            stall_prev = d_out_valid && !d_out_ready;
            prev_data = d_out_data; prev_tag = d_out_tag; prev_inv = d_out_inv;
            cyc++;
        end
        d_in_valid = 1'b0; d_out_ready = 1'b1;
        total++; if (rcv !== 8 || sent !== 8) begin
            bad++; $display("FAIL b2b_count: sent=%0d received=%0d want 8 8", sent, rcv); end
        total++; if (first_out !== 3) begin
            bad++; $display("FAIL b2b_latency: first out cycle=%0d want 3", first_out); end
        total++; if (!saw_full) begin
            bad++; $display("FAIL b2b_backpressure: in_ready never dropped, want low with 3 held"); end
        @(negedge clk);
        total++; if (d_out_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_drain: out_valid=%b want 0", d_out_valid); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        e_out_ready = 1'b1; e_in_valid = 1'b1; e_in_data = FIPS_IN; e_in_inv = 1'b0; e_in_tag = 4'h1;
        @(negedge clk);
        e_in_tag = 4'h2;
        @(negedge clk);
        e_flush = 1'b1; e_in_tag = 4'h3;
        #1;
        total++; if (e_in_ready !== 1'b0) begin
            bad++; $display("FAIL flush_in_ready: got %b want 0", e_in_ready); end
        total++; if (e_out_valid !== 1'b1 || e_out_tag !== 4'h1) begin
            bad++; $display("FAIL flush_pre_out: valid=%b tag=%h want 1 1", e_out_valid, e_out_tag); end
        @(negedge clk);
        e_flush = 1'b0; e_in_valid = 1'b0;
        #1;
        total++; if (e_out_valid !== 1'b0) begin
            bad++; $display("FAIL flush_cleared: out_valid=%b want 0", e_out_valid); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++; if (e_out_valid !== 1'b0) begin
                bad++; $display("FAIL flush_no_accept: cycle %0d out_valid=%b tag=%h want 0", i, e_out_valid, e_out_tag); end
        end
        e_in_valid = 1'b1; e_in_data = FIPS_SR; e_in_inv = 1'b1; e_in_tag = 4'h9;
        #1;
        total++; if (e_in_ready !== 1'b1) begin
            bad++; $display("FAIL flush_ready_after: in_ready=%b want 1", e_in_ready); end
        @(negedge clk);
        e_in_valid = 1'b0;
        total++; if (e_out_valid !== 1'b0) begin
            bad++; $display("FAIL flush_lat_early: out_valid=%b want 0 after 1 cycle", e_out_valid); end
        @(negedge clk);
        total++; if (e_out_valid !== 1'b1 || e_out_tag !== 4'h9 || e_out_data !== FIPS_IN || e_out_inv !== 1'b1) begin
            bad++; $display("FAIL flush_next_block: valid=%b tag=%h data=%h inv=%b want 1 9 %h 1", e_out_valid, e_out_tag, e_out_data, e_out_inv, FIPS_IN); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        e_out_ready = 1'b0; e_in_valid = 1'b1; e_in_data = FIPS_IN; e_in_inv = 1'b0; e_in_tag = 4'h5;
        @(negedge clk);
        e_in_tag = 4'h6;
        @(negedge clk);
        e_in_valid = 1'b0;
        #1;
        total++; if (e_out_valid !== 1'b1 || e_out_tag !== 4'h5) begin
            bad++; $display("FAIL areset_held: valid=%b tag=%h want 1 5", e_out_valid, e_out_tag); end
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (e_out_valid !== 1'b0 || e_out_data !== '0 || e_out_tag !== 4'h0 || e_out_inv !== 1'b0) begin
            bad++; $display("FAIL areset_immediate: valid=%b data=%h tag=%h inv=%b want all zero", e_out_valid, e_out_data, e_out_tag, e_out_inv); end
        @(negedge clk);
        rst_n = 1'b1; e_out_ready = 1'b1;
        @(negedge clk);
        total++; if (e_in_ready !== 1'b1 || e_out_valid !== 1'b0) begin
            bad++; $display("FAIL areset_release: in_ready=%b out_valid=%b want 1 0", e_in_ready, e_out_valid); end
    endtask

    initial begin
        {a_flush, a_in_valid, a_in_inv, a_out_ready} = '0; a_in_data = '0; a_in_tag = '0;
        {b_flush, b_in_valid, b_in_inv, b_out_ready} = '0; b_in_data = '0; b_in_tag = '0;
        {c_flush, c_in_valid, c_in_inv, c_out_ready} = '0; c_in_data = '0; c_in_tag = '0;
        {d_flush, d_in_valid, d_in_inv, d_out_ready} = '0; d_in_data = '0; d_in_tag = '0;
        {e_flush, e_in_valid, e_in_inv, e_out_ready} = '0; e_in_data = '0; e_in_tag = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_fips_nb4();
        test_nb8();
        test_nb6();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
